// File: rtl/bsort100_main.sv
// bsort100 accelerator: fills a 100-word signed array with 100..1, bubble-sorts it ascending, pulses done.
// Define BSORT_SLAVE_EN to enable the dual-channel memory-mapped slave port onto the array.
module bsort100_main #(
  parameter int MEM_var_26078_26084 = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_port,
  input  logic [1:0]   S_oe_ram,
  input  logic [1:0]   S_we_ram,
  input  logic [19:0]  S_addr_ram,
  input  logic [127:0] S_Wdata_ram,
  input  logic [13:0]  S_data_ram_size,
  output logic         done_port,
  output logic [127:0] Sout_Rdata_ram,
  output logic [1:0]   Sout_DataRdy
);

  typedef enum logic [1:0] {IDLE, INIT, SORT, DONE} state_t;

  state_t             state_reg, state_next;
  logic signed [31:0] mem_reg [100];
  logic [6:0]         k_reg, p_reg, j_reg;
  logic               init_last, pass_last, sort_last;

  // Per-channel write requests already qualified for the idle state.
  logic [1:0]         wr;
  logic [1:0][6:0]    idx;
  logic [1:0][31:0]   wdata;

  assign init_last = (k_reg == 7'd99);
  assign pass_last = (j_reg == 7'd98 - p_reg);
  assign sort_last = pass_last && (p_reg == 7'd98);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_port) state_next = INIT;
      INIT:    if (init_last)  state_next = SORT;
      SORT:    if (sort_last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done_port = 1'b0;
    if (state_reg == DONE) done_port = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_reg <= '0;
      p_reg <= '0;
      j_reg <= '0;
    end else begin
      case (state_reg)
        INIT: k_reg <= k_reg + 7'd1;
        SORT: begin
          if (pass_last) begin
            j_reg <= '0;
            p_reg <= p_reg + 7'd1;
          end else begin
            j_reg <= j_reg + 7'd1;
          end
        end
        default: begin
          k_reg <= '0;
          p_reg <= '0;
          j_reg <= '0;
        end
      endcase
    end
  end

  // Slave writes only ever land in IDLE, so they never collide with INIT/SORT updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 100; i++) mem_reg[i] <= '0;
    end else if (state_reg == INIT) begin
      mem_reg[k_reg] <= {25'd0, 7'd100 - k_reg};
    end else if (state_reg == SORT) begin
      if (mem_reg[j_reg] > mem_reg[j_reg + 7'd1]) begin
        mem_reg[j_reg]         <= mem_reg[j_reg + 7'd1];
        mem_reg[j_reg + 7'd1]  <= mem_reg[j_reg];
      end
    end else begin
      for (int c = 0; c < 2; c++)
        if (wr[c]) mem_reg[idx[c]] <= wdata[c];
    end
  end

`ifdef BSORT_SLAVE_EN
  logic [1:0]   req, valid;
  logic [1:0]   rdy_reg;
  logic [127:0] rdata_reg;
  logic         unused_wdata;

  assign unused_wdata = ^{S_Wdata_ram[127:96], S_Wdata_ram[63:32]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [9:0]  addr;
    logic [6:0]  size;
    logic [31:0] byte_addr;

    assign addr      = S_addr_ram[10*gi +: 10];
    assign size      = S_data_ram_size[7*gi +: 7];
    assign byte_addr = 32'(addr);
    assign req[gi]   = S_oe_ram[gi] | S_we_ram[gi];
    assign valid[gi] = req[gi] && (state_reg == IDLE) && (size == 7'd32) &&
                       (addr[1:0] == 2'b00) &&
                       (byte_addr >= 32'(MEM_var_26078_26084)) &&
                       (byte_addr <= 32'(MEM_var_26078_26084 + 396));
    assign wr[gi]    = valid[gi] & S_we_ram[gi];
    assign idx[gi]   = 7'((byte_addr - 32'(MEM_var_26078_26084)) >> 2);
    assign wdata[gi] = S_Wdata_ram[64*gi +: 32];
  end

  // Read data is sampled before this edge's writes, so same-cycle writes return the old word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        rdy_reg[c] <= req[c];
        rdata_reg[64*c +: 64] <= (valid[c] && S_oe_ram[c]) ? {32'd0, mem_reg[idx[c]]} : 64'd0;
      end
    end
  end

  assign Sout_DataRdy   = rdy_reg;
  assign Sout_Rdata_ram = rdata_reg;
`else
  logic unused_slave;

  assign unused_slave   = ^{S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size};
  assign wr             = '0;
  assign idx            = '0;
  assign wdata          = '0;
  assign Sout_DataRdy   = '0;
  assign Sout_Rdata_ram = '0;
`endif

endmodule

// File: tb/tb_bsort100_main.sv
// Self-checking bench for bsort100_main: transaction-level model plus directed vectors.
module tb_bsort100_main;

`ifdef BSORT_SLAVE_EN
  localparam bit SLAVE_EN = 1'b1;
`else
  localparam bit SLAVE_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_port = 1'b0;
  logic [1:0]   S_oe_ram = '0;
  logic [1:0]   S_we_ram = '0;
  logic [19:0]  S_addr_ram = '0;
  logic [127:0] S_Wdata_ram = '0;
  logic [13:0]  S_data_ram_size = '0;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  bsort100_main #(.MEM_var_26078_26084(256)) dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: busy from the start edge until 5051 cycles later; array only observable when idle.
  logic [31:0]  m_mem [100];
  bit           m_busy = 1'b0;
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [1:0]   m_rdy  = '0;
  logic [127:0] m_rdata = '0;
  int           q [$];

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_cnt = 0; m_done = 1'b0; m_rdy = '0; m_rdata = '0;
      for (int k = 0; k < 100; k++) m_mem[k] = '0;
    end else begin
      bit wr_ok [2];
      int wr_idx [2];
      for (int c = 0; c < 2; c++) begin
        int  a;
        bit  req, ok;
        a   = int'(S_addr_ram[10*c +: 10]);
        req = S_oe_ram[c] || S_we_ram[c];
        ok  = SLAVE_EN && req && !m_busy && S_data_ram_size[7*c +: 7] == 7'd32 &&
              (a % 4 == 0) && a >= 256 && a <= 652;
        m_rdy[c]  = SLAVE_EN && req;
        wr_ok[c]  = ok && S_we_ram[c];
        wr_idx[c] = ok ? (a - 256) / 4 : 0;
        m_rdata[64*c +: 64] = (ok && S_oe_ram[c]) ? {32'd0, m_mem[wr_idx[c]]} : 64'd0;
      end
      for (int c = 0; c < 2; c++)
        if (wr_ok[c]) m_mem[wr_idx[c]] = S_Wdata_ram[64*c +: 32];
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 5050) m_done = 1'b1;
        if (m_cnt == 5051) begin
          m_busy = 1'b0;
          q.delete();
          for (int k = 0; k < 100; k++) q.push_back(100 - k);
          q.sort();
          for (int k = 0; k < 100; k++) m_mem[k] = q[k];
        end
      end else if (start_port) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("done_port", {127'd0, done_port}, {127'd0, m_done});
      check("data_rdy", {126'd0, Sout_DataRdy}, {126'd0, m_rdy});
      check("rdata", Sout_Rdata_ram, m_rdata);
    end
  end

  task automatic idle_bus();
    S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
  endtask

  task automatic bus(input logic [1:0] oe, input logic [1:0] we,
                     input logic [9:0] a0, input logic [9:0] a1,
                     input logic [6:0] sz0, input logic [6:0] sz1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     output logic [127:0] rd, output logic [1:0] rdy);
    @(negedge clock);
    S_oe_ram = oe; S_we_ram = we; S_addr_ram = {a1, a0};
    S_data_ram_size = {sz1, sz0}; S_Wdata_ram = {32'd0, d1, 32'd0, d0};
    @(negedge clock);
    rd = Sout_Rdata_ram; rdy = Sout_DataRdy;
    idle_bus();
    $display("bus oe=%b we=%b a0=%0d a1=%0d -> rdy=%b rd0=%0h rd1=%0h",
             oe, we, a0, a1, rdy, rd[31:0], rd[95:64]);
  endtask

  task automatic read1(input int c, input int addr, input int sz,
                       output logic [31:0] w, output logic r);
    logic [127:0] rd;
    logic [1:0]   rdy;
    if (c == 0) bus(2'b01, 2'b00, 10'(addr), 10'd0, 7'(sz), 7'd0, 32'd0, 32'd0, rd, rdy);
    else        bus(2'b10, 2'b00, 10'd0, 10'(addr), 7'd0, 7'(sz), 32'd0, 32'd0, rd, rdy);
    w = rd[64*c +: 32];
    r = rdy[c];
  endtask

  task automatic write1(input int addr, input logic [31:0] d);
    logic [127:0] rd;
    logic [1:0]   rdy;
    bus(2'b00, 2'b01, 10'(addr), 10'd0, 7'd32, 7'd0, d, 32'd0, rd, rdy);
    check("write_rdy", {126'd0, rdy}, 128'd1);
  endtask

  // Start one job; optionally poke start and a slave access while it is sorting.
  task automatic run(input bit pokes);
    int cyc;
    cyc = -1;
    @(negedge clock);
    start_port = 1'b1;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clock);
      if (pokes && i == 2001) begin
        check("busy_rdy", {126'd0, Sout_DataRdy}, SLAVE_EN ? 128'd3 : 128'd0);
        check("busy_rdata", Sout_Rdata_ram, 128'd0);
      end
      start_port = pokes && (i == 1000 || i == 3000);
      idle_bus();
      if (pokes && i == 2000) begin
        S_oe_ram = 2'b01; S_we_ram = 2'b10; S_addr_ram = {10'd256, 10'd256};
        S_data_ram_size = {7'd32, 7'd32}; S_Wdata_ram = {32'd0, 32'hDEAD, 64'd0};
      end
      if (done_port) begin
        cyc = i;
        break;
      end
    end
    start_port = 1'b0;
    idle_bus();
    $display("run pokes=%0d: done seen in cycle %0d", pokes, cyc);
    check("done_cycle", 128'(cyc), 128'd5051);
    @(negedge clock);
    check("done_width", {127'd0, done_port}, 128'd0);
  endtask

  task automatic verify_sorted();
`ifdef BSORT_SLAVE_EN
    logic [31:0] w;
    logic        r;
    for (int k = 0; k < 100; k++) begin
      read1(k % 2, 256 + 4 * k, 32, w, r);
      check("sweep", 128'(w), 128'(k + 1));
    end
`else
    for (int k = 0; k < 100; k++)
      check("array", 128'(dut.mem_reg[k]), 128'(k + 1));
`endif
  endtask

  initial begin
    logic [127:0] rd;
    logic [1:0]   rdy;
    logic [31:0]  w;
    logic         r;

    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    reset  = 1'b0;
    check("reset_done", {127'd0, done_port}, 128'd0);
    check("reset_rdy", {126'd0, Sout_DataRdy}, 128'd0);

    run(1'b0);
`ifdef BSORT_SLAVE_EN
    bus(2'b11, 2'b00, 10'd256, 10'd652, 7'd32, 7'd32, 32'd0, 32'd0, rd, rdy);
    check("dual_rdy", {126'd0, rdy}, 128'd3);
    check("dual_ch0", 128'(rd[31:0]), 128'd1);
    check("dual_ch1", 128'(rd[95:64]), 128'd100);
    verify_sorted();

    write1(260, 32'hFFFF_FFFF);
    read1(0, 260, 32, w, r);
    check("wr_readback", 128'(w), 128'hFFFF_FFFF);
    read1(0, 258, 32, w, r);
    check("misalign_rdy", 128'(r), 128'd1);
    check("misalign_data", 128'(w), 128'd0);
    read1(1, 656, 32, w, r);
    check("oor_hi_rdy", 128'(r), 128'd1);
    check("oor_hi_data", 128'(w), 128'd0);
    read1(1, 252, 32, w, r);
    check("oor_lo_data", 128'(w), 128'd0);
    read1(0, 264, 16, w, r);
    check("size16_rdy", 128'(r), 128'd1);
    check("size16_data", 128'(w), 128'd0);
    bus(2'b00, 2'b01, 10'd258, 10'd0, 7'd32, 7'd0, 32'h1234, 32'd0, rd, rdy);
    read1(0, 256, 32, w, r);
    check("rejected_wr_256", 128'(w), 128'd1);
    read1(1, 260, 32, w, r);
    check("rejected_wr_260", 128'(w), 128'hFFFF_FFFF);

    bus(2'b01, 2'b01, 10'd264, 10'd0, 7'd32, 7'd0, 32'h55, 32'd0, rd, rdy);
    check("oe_we_old", 128'(rd[31:0]), 128'd3);
    read1(0, 264, 32, w, r);
    check("oe_we_new", 128'(w), 128'h55);

    bus(2'b00, 2'b11, 10'd300, 10'd300, 7'd32, 7'd32, 32'd5, 32'd7, rd, rdy);
    read1(0, 300, 32, w, r);
    check("ch1_wins", 128'(w), 128'd7);

    bus(2'b10, 2'b01, 10'd304, 10'd304, 7'd32, 7'd32, 32'd9, 32'd0, rd, rdy);
    check("cross_old", 128'(rd[95:64]), 128'd13);
    read1(1, 304, 32, w, r);
    check("cross_new", 128'(w), 128'd9);
`else
    verify_sorted();
    read1(0, 256, 32, w, r);
    check("disabled_rdy", 128'(r), 128'd0);
    check("disabled_data", 128'(w), 128'd0);
`endif

    run(1'b1);
    verify_sorted();
`ifdef BSORT_SLAVE_EN
    read1(0, 260, 32, w, r);
    check("reinit_260", 128'(w), 128'd2);
`endif

    // Abort a job about 2000 cycles into SORT, then run a full job again.
    @(negedge clock);
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    repeat (2099) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_done", {127'd0, done_port}, 128'd0);
    $display("abort: reset applied mid-sort");
    run(1'b1);
    verify_sorted();

    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bsort100_main.md
Name: bsort100_main

Overview:
- Top-level accelerator for the bsort100 kernel, as generated by the HLS flow.
- On a start pulse it fills an internal 100-entry array of signed 32-bit integers with a fixed descending pattern, then sorts it ascending by bubble sort and pulses done.
- The array is also reachable through a dual-channel memory-mapped slave port, so the system can inspect or preload it while the block is idle.

Parameters:
- MEM_var_26078_26084, default 256: byte base address of the array in the slave address space. The array spans base to base+399, 4 bytes per element, little-endian element order (element k at base+4k).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_port  in  1  start request, sampled on a rising edge while IDLE
- S_oe_ram  in  2  per-channel read enable (bit c = channel c)
- S_we_ram  in  2  per-channel write enable
- S_addr_ram  in  20  per-channel byte address, channel c at [10c+9:10c]
- S_Wdata_ram  in  128  per-channel write data, channel c at [64c+63:64c]
- S_data_ram_size  in  14  per-channel access size in bits, channel c at [7c+6:7c]
- done_port  out  1  one-cycle completion pulse
- Sout_Rdata_ram  out  128  per-channel read data, same slicing as write data
- Sout_DataRdy  out  2  per-channel access-complete pulse

Behaviour:
- Clock and reset: one clock (`clock`); reset is synchronous and active-high (`reset`).
- Reset: state IDLE, done_port=0, Sout_Rdata_ram=0, Sout_DataRdy=0, all array words 0, counters 0. Reset mid-operation aborts the operation and returns to IDLE. No done pulse is produced.
- Array storage: register file of 100 x 32 bits.
- FSM states: IDLE, INIT, SORT, DONE.
- IDLE -> INIT on start_port=1. Define cycle 0 as the edge that samples start.
- INIT: one write per cycle, array[k] = 100-k for k=0..99. Occupies cycles 1..100.
- SORT: outer pass p=0..98; inner index j=0..98-p.
  - One compare-and-swap per cycle, signed compare.
  - If array[j] > array[j+1], swap the two elements.
  - 4950 cycles total, occupying cycles 101..5050.
- DONE: done_port=1 for exactly cycle 5051, then IDLE.
- start_port asserted while not in IDLE is ignored. No queuing.
- Slave port, each channel independent:
  - A request is S_oe_ram[c] or S_we_ram[c] high.
  - Sout_DataRdy[c] pulses exactly one cycle after each request, always, even when the access is rejected.
  - A valid access requires all of: state IDLE; size field = 32; address 4-aligned; base <= address <= base+396.
  - Valid read: Rdata channel c = {32'b0, word} on the DataRdy cycle.
  - Valid write: word = Wdata[31:0] of that channel, taking effect at the request edge.
  - Rejected access: no array change; read data 0.
  - Rdata returns to 0 on cycles without DataRdy.
  - If oe and we are both high on one channel, the write is performed and the read data returns the old word.
  - If both channels write the same word in the same cycle, channel 1 wins.
  - A read of a word written in the same cycle by the other channel returns the old value.
- Arithmetic: signed 32-bit compare only; no overflow is possible.

Optional Feature:
- Macro: BSORT_SLAVE_EN.
- Defined: slave port behaves as described above.
- Undefined: S_* inputs are ignored; Sout_Rdata_ram and Sout_DataRdy are tied to 0. Compute behaviour and latency are unchanged.

Test Plan:
- Reset for 2 cycles, then pulse start_port for 1 cycle -> done_port high exactly at cycle 5051 after the start edge, for exactly 1 cycle.
- After done, with BSORT_SLAVE_EN, read ch0 at address 256 and ch1 at address 652 -> DataRdy=2'b11 next cycle; Rdata[31:0]=1 and Rdata[95:64]=100. A full sweep of all 100 words returns 1..100 in order.
- In IDLE, write ch0 address 260 with 0xFFFFFFFF (size 32), then read it back -> returns 0xFFFFFFFF. Start again -> INIT overwrites it; final word at 260 = 2.
- Read at address 258 (misaligned), at address 656 (out of range), with size 16, and any access during SORT -> DataRdy still pulses, data 0, array unchanged.
- Assert reset at cycle 2000 of SORT, then start again -> done at 5051 cycles after the new start; final contents 1..100. Start pulses issued during SORT produce no extra done.
- Both channels write address 300 in the same cycle (ch0=5, ch1=7) -> readback is 7.
